// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: fetch FSM states, next-PC select encodings, NOP word.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_t;

  // Encoding 11 is reserved and behaves as sequential fetch.
  function automatic logic is_redirect(input logic [1:0] pcsrc);
    return (pcsrc == PCSRC_TARGET) || (pcsrc == PCSRC_JALR);
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats stall beats load; no load means a NOP bubble.
module if_id_register
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_instr    <= NOP;
      o_pc       <= '0;
      o_pc_plus4 <= '0;
      o_valid    <= 1'b0;
    end else if (i_flush) begin
      o_instr <= NOP;
      o_valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_load) begin
        o_instr    <= i_instr;
        o_pc       <= i_pc;
        o_pc_plus4 <= i_pc + 32'd4;
        o_valid    <= 1'b1;
      end else begin
        // Bubble keeps PCD/PCPlus4D so decode still sees the last real PC.
        o_instr <= NOP;
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, next-PC select, single-outstanding imem handshake,
// one-entry skid buffer for responses arriving while decode is stalled, and IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);
  import riscv_pkg::*;

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pcf, r_req_pc, r_buf_instr, r_buf_pc;
  logic         r_buf_v;
  logic         w_redirect, w_rsp_live, w_accept, w_buf_drain, w_ifid_load;
  logic [31:0]  w_target, w_ifid_instr, w_ifid_pc;

  assign w_redirect = is_redirect(PCSrcE);
  assign w_target   = (PCSrcE == PCSRC_JALR) ? {ALUResultE[31:1], 1'b0} : PCTargetE;
  assign w_rsp_live = (r_state == FS_WAIT) && imem_rvalid;

  always_comb begin
    imem_req    = 1'b0;
    w_state_nxt = r_state;
    // A new request may overlap the live response only when decode can take it.
    if (rst_n && !w_redirect && !StallF && !r_buf_v)
      imem_req = (r_state == FS_REQ) || (w_rsp_live && !StallD);
    w_accept = imem_req && imem_ready;
    if (w_accept) begin
      w_state_nxt = FS_WAIT;
    end else begin
      case (r_state)
        FS_WAIT: begin
          if (imem_rvalid)     w_state_nxt = FS_REQ;
          else if (w_redirect) w_state_nxt = FS_DROP;
        end
        FS_DROP: if (imem_rvalid) w_state_nxt = FS_REQ;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign w_buf_drain  = r_buf_v && !FlushD && !StallD;
  assign w_ifid_load  = r_buf_v || (w_rsp_live && !w_redirect);
  assign w_ifid_instr = r_buf_v ? r_buf_instr : imem_rdata;
  assign w_ifid_pc    = r_buf_v ? r_buf_pc    : r_req_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FS_REQ;
      r_pcf       <= RESET_PC;
      r_req_pc    <= '0;
      r_buf_v     <= 1'b0;
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_redirect)    r_pcf <= w_target;
      else if (w_accept) r_pcf <= r_pcf + 32'd4;
      if (w_accept) r_req_pc <= r_pcf;
      if (w_redirect) begin
        r_buf_v <= 1'b0;
      end else if (w_rsp_live && StallD) begin
        r_buf_v     <= 1'b1;
        r_buf_instr <= imem_rdata;
        r_buf_pc    <= r_req_pc;
      end else if (w_buf_drain) begin
        r_buf_v <= 1'b0;
      end
    end
  end

  assign PCF       = r_pcf;
  assign imem_addr = r_pcf;

  if_id_register #(
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (FlushD),
    .i_stall    (StallD),
    .i_load     (w_ifid_load),
    .i_instr    (w_ifid_instr),
    .i_pc       (w_ifid_pc),
    .o_instr    (InstrD),
    .o_pc       (PCD),
    .o_pc_plus4 (PCPlus4D),
    .o_valid    (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level reference model checked every cycle,
// a latency-programmable instruction memory, and directed scenarios with literal checks.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .ALUResultE (ALUResultE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {8'hAB, a[23:0]};
  endfunction

  // Instruction memory: each accepted address answers mem_lat cycles later, in order.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t mq[$];
  int   cyc     = 0;
  int   mem_lat = 1;

  always @(negedge clk)
    if (rst_n === 1'b1 && imem_req === 1'b1 && imem_ready === 1'b1)
      mq.push_back('{imem_addr, cyc + mem_lat});

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = tag(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Reference model: PC, the single outstanding fetch (live or abandoned), skid slot, decode slot.
  logic [31:0] m_pc, m_req_pc, m_buf_i, m_buf_pc, m_instr, m_pcd, m_pc4;
  bit          m_out, m_live, m_buf_v, m_vd;

  always @(negedge clk) begin
    bit          redir, live_rsp, exp_req, acc, old_bv;
    logic [31:0] tgt;
    if (rst_n !== 1'b1) begin
      m_pc = 32'h0; m_req_pc = 32'h0; m_out = 0; m_live = 0; m_buf_v = 0;
      m_buf_i = 32'h0; m_buf_pc = 32'h0;
      m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_vd = 0;
    end
    redir    = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    tgt      = (PCSrcE == 2'b10) ? {ALUResultE[31:1], 1'b0} : PCTargetE;
    live_rsp = m_out && m_live && (imem_rvalid === 1'b1);
    exp_req  = (rst_n === 1'b1) && !redir && !StallF && !m_buf_v &&
               (!m_out || (live_rsp && !StallD));
    chk("imem_req",  32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("PCF",       PCF, m_pc);
    chk("InstrD",    InstrD, m_instr);
    chk("PCD",       PCD, m_pcd);
    chk("PCPlus4D",  PCPlus4D, m_pc4);
    chk("ValidD",    32'(ValidD), 32'(m_vd));
    if (rst_n === 1'b1) begin
      acc    = exp_req && imem_ready;
      old_bv = m_buf_v;
      if (FlushD) begin
        m_instr = NOP; m_vd = 0;
      end else if (!StallD) begin
        if (old_bv) begin
          m_instr = m_buf_i; m_pcd = m_buf_pc; m_pc4 = m_buf_pc + 32'd4; m_vd = 1;
        end else if (live_rsp && !redir) begin
          m_instr = imem_rdata; m_pcd = m_req_pc; m_pc4 = m_req_pc + 32'd4; m_vd = 1;
        end else begin
          m_instr = NOP; m_vd = 0;
        end
      end
      if (redir) m_buf_v = 0;
      else if (live_rsp && StallD) begin
        m_buf_v = 1; m_buf_i = imem_rdata; m_buf_pc = m_req_pc;
      end else if (old_bv && !FlushD && !StallD) m_buf_v = 0;
      if (acc) begin
        m_out = 1; m_live = 1; m_req_pc = m_pc;
      end else if (m_out && imem_rvalid === 1'b1) m_out = 0;
      else if (m_out && redir) m_live = 0;
      m_pc = redir ? tgt : (acc ? m_pc + 32'd4 : m_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 2'b00;
    PCTargetE = '0; ALUResultE = '0; imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_instr", InstrD, 32'h0000_0013);
    chk("rst_valid", 32'(ValidD), 32'h0);
    tick(); rst_n = 1'b1;                                   // C0
    #2; chk("c0_req", 32'(imem_req), 32'h1); chk("c0_addr", imem_addr, 32'h0);
    tick();                                                 // C1
    tick();                                                 // C2
    #2; chk("c2_pcd", PCD, 32'h0); chk("c2_valid", 32'(ValidD), 32'h1);
    chk("c2_instr", InstrD, 32'hAB00_0000);
    tick(); StallF = 1; StallD = 1;                         // C3: response for PC 8 arrives
    #2; chk("c3_pcd", PCD, 32'h4); chk("c3_req", 32'(imem_req), 32'h0);
    tick(); StallF = 0; StallD = 0;                         // C4
    #2; chk("c4_pcd_hold", PCD, 32'h4); chk("c4_req_bufv", 32'(imem_req), 32'h0);
    tick(); mem_lat = 2;                                    // C5
    #2; chk("c5_pcd", PCD, 32'h8); chk("c5_valid", 32'(ValidD), 32'h1);
    chk("c5_addr", imem_addr, 32'hC);
    tick(); PCSrcE = 2'b01; PCTargetE = 32'h100; FlushD = 1; // C6: WAIT for 0xC
    #2; chk("c6_req", 32'(imem_req), 32'h0);
    tick(); PCSrcE = 2'b00; FlushD = 0;                     // C7: stale 0xC arrives
    #2; chk("c7_valid", 32'(ValidD), 32'h0); chk("c7_instr", InstrD, 32'h13);
    chk("c7_req", 32'(imem_req), 32'h0); chk("c7_pcf", PCF, 32'h100);
    tick(); mem_lat = 1;                                    // C8
    #2; chk("c8_req", 32'(imem_req), 32'h1); chk("c8_addr", imem_addr, 32'h100);
    tick();                                                 // C9
    tick(); PCSrcE = 2'b10; ALUResultE = 32'h203;           // C10
    #2; chk("c10_pcd", PCD, 32'h100); chk("c10_valid", 32'(ValidD), 32'h1);
    tick(); PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFFC;      // C11
    #2; chk("c11_addr", imem_addr, 32'h202); chk("c11_valid", 32'(ValidD), 32'h0);
    tick(); PCSrcE = 2'b00;                                 // C12
    #2; chk("c12_req", 32'(imem_req), 32'h1); chk("c12_addr", imem_addr, 32'hFFFF_FFFC);
    tick();                                                 // C13
    #2; chk("c13_wrap", PCF, 32'h0);
    tick(); StallD = 1; FlushD = 1; PCSrcE = 2'b01; PCTargetE = 32'h300; // C14
    #2; chk("c14_pcd", PCD, 32'hFFFF_FFFC); chk("c14_pc4", PCPlus4D, 32'h0);
    tick(); StallD = 0; FlushD = 0; PCSrcE = 2'b00;         // C15
    #2; chk("c15_valid", 32'(ValidD), 32'h0); chk("c15_req", 32'(imem_req), 32'h1);
    chk("c15_addr", imem_addr, 32'h300);

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      tick();
      r          = $urandom_range(0, 11);
      StallF     = ($urandom_range(0, 3) == 0);
      StallD     = ($urandom_range(0, 4) == 0);
      FlushD     = ($urandom_range(0, 7) == 0);
      PCSrcE     = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      PCTargetE  = 32'($urandom_range(0, 1023)) << 2;
      ALUResultE = 32'($urandom_range(0, 4095));
      imem_ready = ($urandom_range(0, 3) != 0);
      mem_lat    = int'($urandom_range(1, 3));
    end

    // Reset right after an accept with the response still in flight.
    tick(); StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 2'b00; imem_ready = 1; mem_lat = 2;
    repeat (4) tick();
    rst_n = 1'b0;
    #2; chk("mid_rst_pcf", PCF, 32'h0); chk("mid_rst_req", 32'(imem_req), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    #2; chk("post_rst_req", 32'(imem_req), 32'h1); chk("post_rst_addr", imem_addr, 32'h0);
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
